wb_byte_sequencer: RTL and testbench

Serialises Wishbone word accesses into one-byte-per-cycle accesses on a byte-addressed register port. It sits between the Wishbone slave decode and a byte-enable register bank with a combinational `q_byte` read. For writes it walks the byte lanes and issues a one-byte write per enabled lane. For reads it steps the same lane index and assembles a word from the bank's combinational read byte, then acknowledges the access.

---
 rtl/wb_byte_sequencer.sv | 131 +++++++++++++
 tb/tb_wb_byte_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_sequencer.sv
// Serialises Wishbone word accesses into one-byte-per-cycle register-bank accesses.
// Optional macro WB_BYTE_SEQ_SKIP_EN: visit only enabled lanes (variable latency).
module wb_byte_sequencer #(
    parameter int unsigned DATA_W_BYTES = 4,
    parameter int unsigned SEL_WIDTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [DATA_W_BYTES-1:0]   wb_sel_i,
    input  logic [8*DATA_W_BYTES-1:0] wb_dat_i,
    output logic [8*DATA_W_BYTES-1:0] wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      reg_we,
    output logic [SEL_WIDTH-1:0]      reg_byte_sel,
    output logic [7:0]                reg_d_byte,
    input  logic [7:0]                reg_q_byte
);

    localparam int unsigned DataW = 8 * DATA_W_BYTES;
`ifndef WB_BYTE_SEQ_SKIP_EN
    localparam logic [SEL_WIDTH-1:0] LastIdx = SEL_WIDTH'(DATA_W_BYTES - 1);
`endif

    typedef enum logic [1:0] {StIdle, StXfer, StAck} state_e;

    state_e                state_q, state_d;
    logic [SEL_WIDTH-1:0]  idx_q, idx_d;
    logic                  we_q;
    logic [DATA_W_BYTES-1:0] sel_q;
    logic [DataW-1:0]      dat_q;
    logic [DataW-1:0]      rdata_q, rdata_d;
    logic                  accept;

    assign accept = (state_q == StIdle) && wb_cyc_i && wb_stb_i;

`ifdef WB_BYTE_SEQ_SKIP_EN
    // Lowest enabled lane at or above 'from'; MSB of the result flags that one exists.
    function automatic logic [SEL_WIDTH:0] next_lane(input logic [DATA_W_BYTES-1:0] sel,
                                                     input int from);
        logic [SEL_WIDTH:0] r;
        r = '0;
        for (int i = int'(DATA_W_BYTES) - 1; i >= 0; i--) begin
            if (i >= from && sel[i]) r = {1'b1, SEL_WIDTH'(i)};
        end
        return r;
    endfunction

    logic [SEL_WIDTH:0] lane;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rdata_d      = rdata_q;
        reg_we       = 1'b0;
        reg_byte_sel = '0;
        reg_d_byte   = '0;
`ifdef WB_BYTE_SEQ_SKIP_EN
        lane         = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!wb_we_i) rdata_d = '0;
`ifdef WB_BYTE_SEQ_SKIP_EN
                    lane    = next_lane(wb_sel_i, 0);
                    idx_d   = lane[SEL_WIDTH-1:0];
                    state_d = lane[SEL_WIDTH] ? StXfer : StAck;
`else
                    idx_d   = '0;
                    state_d = StXfer;
`endif
                end
            end
            StXfer: begin
                reg_byte_sel = idx_q;
                reg_d_byte   = dat_q[idx_q*8 +: 8];
                if (!wb_cyc_i) begin
                    // Abort: nothing is written or captured in the abandoned lane.
                    state_d = StIdle;
                end else begin
                    reg_we = we_q & sel_q[idx_q];
                    if (!we_q && sel_q[idx_q]) rdata_d[idx_q*8 +: 8] = reg_q_byte;
`ifdef WB_BYTE_SEQ_SKIP_EN
                    lane = next_lane(sel_q, int'(idx_q) + 1);
                    if (lane[SEL_WIDTH]) idx_d = lane[SEL_WIDTH-1:0];
                    else                 state_d = StAck;
`else
                    if (idx_q == LastIdx) state_d = StAck;
                    else                  idx_d = idx_q + 1'b1;
`endif
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A lane interrupted by reset must not reach the bank.
        if (rst) reg_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
            end
        end
    end

    assign wb_dat_o = rdata_q;
    assign wb_ack_o = (state_q == StAck);

endmodule

// File: tb/tb_wb_byte_sequencer.sv
// Self-checking bench for wb_byte_sequencer: lane-list reference model, per-cycle compare,
// directed literal checks and randomized accesses. Honours WB_BYTE_SEQ_SKIP_EN.
module tb_wb_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, dat_o;
    logic        ack, reg_we;
    logic [1:0]  reg_sel;
    logic [7:0]  reg_d, reg_q;

    always #5 clk = ~clk;

`ifdef WB_BYTE_SEQ_SKIP_EN
    localparam bit Skip = 1'b1;
`else
    localparam bit Skip = 1'b0;
`endif

    wb_byte_sequencer #(.DATA_W_BYTES(4), .SEL_WIDTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_cyc_i     (cyc),
        .wb_stb_i     (stb),
        .wb_we_i      (we),
        .wb_sel_i     (sel),
        .wb_dat_i     (dat_i),
        .wb_dat_o     (dat_o),
        .wb_ack_o     (ack),
        .reg_we       (reg_we),
        .reg_byte_sel (reg_sel),
        .reg_d_byte   (reg_d),
        .reg_q_byte   (reg_q)
    );

    // Register bank seen by the DUT, and the model's view of what it must contain.
    logic [7:0] bank  [4];
    logic [7:0] mbank [4];
    assign reg_q = bank[reg_sel];
    always @(posedge clk) if (reg_we) bank[reg_sel] <= reg_d;

    int n_cmp = 0;
    int n_err = 0;
    logic        chk_en = 1'b0;
    logic        e_ack, e_we;
    logic [1:0]  e_sel;
    logic [7:0]  e_d;
    logic [31:0] e_dat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wb_ack_o", 32'(ack), 32'(e_ack));
            chk("reg_we", 32'(reg_we), 32'(e_we));
            chk("reg_byte_sel", 32'(reg_sel), 32'(e_sel));
            chk("reg_d_byte", 32'(reg_d), 32'(e_d));
            chk("wb_dat_o", dat_o, e_dat);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_ack = 1'b0; e_we = 1'b0; e_sel = 2'd0; e_d = 8'd0;
    endtask

    function automatic logic [31:0] bank_word();
        return {bank[3], bank[2], bank[1], bank[0]};
    endfunction

    function automatic logic [31:0] mbank_word();
        return {mbank[3], mbank[2], mbank[1], mbank[0]};
    endfunction

    // One access starting in the current (IDLE) cycle. abort_at/rst_at name the cycle in
    // which cyc drops or rst rises (0 = never). ack_cyc returns the observed ack cycle or -1.
    task automatic access(input logic w, input logic [3:0] s, input logic [31:0] d,
                          input int abort_at, input int rst_at, output int ack_cyc);
        int lanes[$];
        int n;
        int cnt;
        ack_cyc = -1;
        cnt = 0;
        for (int i = 0; i < 4; i++) if (!Skip || s[i]) lanes.push_back(i);
        n = lanes.size();
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_i = d;
        idle_exp();
        tick(); cnt++;
        if (ack === 1'b1) ack_cyc = cnt;
        if (!w) e_dat = 32'd0;
        for (int k = 1; k <= n; k++) begin
            int  ln;
            bit  cut;
            ln  = lanes[k-1];
            cut = (k == abort_at) || (k == rst_at);
            e_ack = 1'b0;
            e_sel = 2'(ln);
            e_d   = d[8*ln +: 8];
            e_we  = w && s[ln] && !cut;
            if (k == abort_at) begin cyc = 1'b0; stb = 1'b0; end
            if (k == rst_at) rst = 1'b1;
            tick(); cnt++;
            if (ack === 1'b1) ack_cyc = cnt;
            if (cut) begin
                idle_exp();
                cyc = 1'b0; stb = 1'b0;
                if (k == rst_at) begin
                    rst = 1'b0;
                    e_dat = 32'd0;
                end
                return;
            end
            if (w && s[ln]) mbank[ln] = d[8*ln +: 8];
            if (!w && s[ln]) e_dat[8*ln +: 8] = mbank[ln];
        end
        // ACK cycle; strobe is still high here and must be ignored.
        idle_exp();
        e_ack = 1'b1;
        tick(); cnt++;
        idle_exp();
        cyc = 1'b0; stb = 1'b0;
        if (ack === 1'b1) ack_cyc = cnt;
    endtask

    int ac;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; dat_i = 32'd0;
        e_dat = 32'd0;
        idle_exp();
        tick(); tick();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("reset_dat_o", dat_o, 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);

        // Full write.
        access(1'b1, 4'b1111, 32'hA1B2C3D4, 0, 0, ac);
        chk("full_ack_cycle", ac, 5);
        chk("full_bank", bank_word(), 32'hA1B2C3D4);

        // Partial write over a known bank image.
        access(1'b1, 4'b1111, 32'h44332211, 0, 0, ac);
        access(1'b1, 4'b0101, 32'hA1B2C3D4, 0, 0, ac);
        chk("partial_ack_cycle", ac, Skip ? 3 : 5);
        chk("partial_bank", bank_word(), 32'h44B222D4);

        // Reads.
        access(1'b1, 4'b1111, 32'h44332211, 0, 0, ac);
        access(1'b0, 4'b1111, 32'h0, 0, 0, ac);
        chk("read_full", dat_o, 32'h44332211);
        chk("read_full_ack_cycle", ac, 5);
        access(1'b0, 4'b0011, 32'h0, 0, 0, ac);
        chk("read_partial", dat_o, 32'h00002211);

        // Abort in cycle 2, then a normal read.
        access(1'b1, 4'b1111, 32'hDEADBEEF, 2, 0, ac);
        chk("abort_no_ack", ac, -1);
        chk("abort_bank", bank_word(), 32'h443322EF);
        access(1'b0, 4'b1111, 32'h0, 0, 0, ac);
        chk("after_abort_read", dat_o, 32'h443322EF);

        // Reset in cycle 3 of a write.
        access(1'b1, 4'b1111, 32'h44332211, 0, 0, ac);
        access(1'b1, 4'b1111, 32'hDEADBEEF, 0, 3, ac);
        chk("reset_no_ack", ac, -1);
        chk("reset_bank", bank_word(), 32'h4433BEEF);
        chk("reset_clears_dat", dat_o, 32'd0);

        // Sparse enables: empty and top-lane-only.
        access(1'b1, 4'b0000, 32'h99999999, 0, 0, ac);
        chk("sel0_ack_cycle", ac, Skip ? 1 : 5);
        chk("sel0_bank", bank_word(), 32'h4433BEEF);
        access(1'b1, 4'b1000, 32'h77000000, 0, 0, ac);
        chk("sel8_ack_cycle", ac, Skip ? 2 : 5);
        chk("sel8_bank", bank_word(), 32'h7733BEEF);

        // Randomized accesses, with occasional abort or reset.
        for (int t = 0; t < 150; t++) begin
            int r, ab, rs;
            r  = int'($urandom_range(0, 15));
            ab = (r == 0) ? int'($urandom_range(1, 4)) : 0;
            rs = (r == 1) ? int'($urandom_range(1, 4)) : 0;
            access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, ab, rs, ac);
            chk("rand_bank", bank_word(), mbank_word());
            if ($urandom_range(0, 3) == 0) tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
